// File: rtl/spi_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  spi_regfile_pkg : shared types and helpers for the SPI register-file target
//  Rev 1.0
// ============================================================================
package spi_regfile_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    DATA    = 3'd2,
    WAIT_CS = 3'd3,
    COMMIT  = 3'd4
  } state_e;

  localparam logic RW_WRITE = 1'b1;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_regfile_peripheral_if.sv
`default_nettype none
// ============================================================================
//  spi_regfile_peripheral_if : SPI pin bundle between host and target
//  Rev 1.0
// ============================================================================
interface spi_regfile_peripheral_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output ncs, output copi, input cipo, input cipo_oe);
  modport slave  (input sclk, input ncs, input copi, output cipo, output cipo_oe);
endinterface
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
//  sync_edge_detect : multi-flop synchroniser with rise/fall pulse outputs
//  Rev 1.0
// ============================================================================
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_regfile_peripheral.sv
`default_nettype none
// ============================================================================
//  spi_regfile_peripheral : SPI mode-0 target with NUM_REGS x DATA_W registers
//  Rev 1.0
// ============================================================================
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  spi_regfile_peripheral_if.slave      spi,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int CMD_W      = 1 + ADDR_W;
  localparam int FRAME_W    = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W      = $clog2(FRAME_W + 1);
  localparam int SETTLE_MAX = SYNC_STAGES + 1;
  localparam int SETTLE_W   = $clog2(SETTLE_MAX + 1);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic ncs_level, ncs_rise, ncs_fall;
  logic copi_level, copi_rise_unused, copi_fall_unused;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(spi.sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall));

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .d(spi.ncs),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall));

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .d(spi.copi),
    .level(copi_level), .rise(copi_rise_unused), .fall(copi_fall_unused));

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CMD_W-1:0]     cmd_q, cmd_d;
  logic [DATA_W-1:0]    data_in_q, data_in_d;
  logic [DATA_W-1:0]    shift_out_q, shift_out_d;
  logic                 oe_q, oe_d;
  logic                 overrun_q, overrun_d;
  logic                 discard_q, discard_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [DATA_W-1:0]    regs_d [NUM_REGS];

  logic [CMD_W-1:0]     cmd_shift;
  logic [DATA_W-1:0]    preload;
  logic                 settled;

  assign cmd_shift = {cmd_q[CMD_W-2:0], copi_level};
  assign settled   = (settle_q == SETTLE_W'(SETTLE_MAX));

  // Read data is captured from the registers as they stand when the address completes.
  always_comb begin
    preload = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (cmd_shift[ADDR_W-1:0] == ADDR_W'(r)) preload = regs_q[r];
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    data_in_d   = data_in_q;
    shift_out_d = shift_out_q;
    oe_d        = oe_q;
    overrun_d   = overrun_q;
    discard_d   = discard_q;
    settle_d    = settled ? settle_q : settle_q + SETTLE_W'(1);
    regs_d      = regs_q;
    wr_strobe   = '0;
    frame_err   = 1'b0;

    case (state_q)
      IDLE: begin
        // Edges are untrustworthy until the ncs synchroniser has flushed its reset value;
        // a select already low at that point belongs to a frame we never saw start.
        if (settled) begin
          if (ncs_fall) begin
            state_d   = CMD;
            bit_cnt_d = '0;
            overrun_d = 1'b0;
            discard_d = 1'b0;
            oe_d      = 1'b0;
          end else if (!ncs_level) begin
            state_d   = WAIT_CS;
            discard_d = 1'b1;
          end
        end
      end

      CMD: begin
        if (ncs_rise) begin
          state_d   = IDLE;
          frame_err = 1'b1;
        end else if (sclk_rise) begin
          cmd_d = cmd_shift;
          if (bit_cnt_q == CNT_W'(ADDR_W)) begin
            state_d     = DATA;
            bit_cnt_d   = '0;
            shift_out_d = preload;
            oe_d        = (cmd_shift[CMD_W-1] != RW_WRITE);
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      DATA: begin
        if (ncs_rise) begin
          state_d   = IDLE;
          frame_err = 1'b1;
          oe_d      = 1'b0;
        end else begin
          if (sclk_rise) begin
            data_in_d = (data_in_q << 1) | DATA_W'(copi_level);
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              state_d   = WAIT_CS;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          // The fall right after entering DATA precedes the host's sample of the MSB.
          if (sclk_fall && (bit_cnt_q != '0)) shift_out_d = shift_out_q << 1;
        end
      end

      WAIT_CS: begin
        if (ncs_rise) begin
          state_d = discard_q ? IDLE : COMMIT;
          oe_d    = 1'b0;
        end else begin
          if (sclk_rise) overrun_d = 1'b1;
          if (sclk_fall) shift_out_d = shift_out_q << 1;
        end
      end

      COMMIT: begin
        state_d = IDLE;
        if (overrun_q) begin
          frame_err = 1'b1;
        end else if (cmd_q[CMD_W-1] == RW_WRITE) begin
          for (int r = 0; r < NUM_REGS; r++) begin
            if (cmd_q[ADDR_W-1:0] == ADDR_W'(r)) begin
              regs_d[r]    = data_in_q;
              wr_strobe[r] = 1'b1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      data_in_q   <= '0;
      shift_out_q <= '0;
      oe_q        <= 1'b0;
      overrun_q   <= 1'b0;
      discard_q   <= 1'b0;
      settle_q    <= '0;
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      data_in_q   <= data_in_d;
      shift_out_q <= shift_out_d;
      oe_q        <= oe_d;
      overrun_q   <= overrun_d;
      discard_q   <= discard_d;
      settle_q    <= settle_d;
      regs_q      <= regs_d;
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_flat
      assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end
  endgenerate

  assign spi.cipo    = oe_q & shift_out_q[DATA_W-1];
  assign spi.cipo_oe = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_regfile_peripheral.sv
`default_nettype none
// ============================================================================
//  tb_spi_regfile_peripheral : directed bench for default and 16x16 variants
//  Rev 1.0
// ============================================================================
module tb_spi_regfile_peripheral;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic copi = 1'b0;
  logic ncs_a = 1'b1;
  logic ncs_b = 1'b1;

  always #5 clk = ~clk;

  spi_regfile_peripheral_if spi_a ();
  spi_regfile_peripheral_if spi_b ();

  assign spi_a.sclk = sclk;
  assign spi_a.copi = copi;
  assign spi_a.ncs  = ncs_a;
  assign spi_b.sclk = sclk;
  assign spi_b.copi = copi;
  assign spi_b.ncs  = ncs_b;

  logic [63:0]  regs_flat_a;
  logic [7:0]   wr_strobe_a;
  logic         frame_err_a;
  logic [255:0] regs_flat_b;
  logic [15:0]  wr_strobe_b;
  logic         frame_err_b;

  spi_regfile_peripheral u_dut_a (
    .clk(clk), .rst(rst), .spi(spi_a.slave),
    .regs_flat(regs_flat_a), .wr_strobe(wr_strobe_a), .frame_err(frame_err_a));

  spi_regfile_peripheral #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .rst(rst), .spi(spi_b.slave),
    .regs_flat(regs_flat_b), .wr_strobe(wr_strobe_b), .frame_err(frame_err_b));

  int checks = 0;
  int errors = 0;
  int strobe_cnt_a = 0, err_cnt_a = 0, strobe_cnt_b = 0, err_cnt_b = 0;
  logic [7:0]  last_strobe_a = '0;
  logic [15:0] last_strobe_b = '0;

  always @(negedge clk) begin
    if (wr_strobe_a != '0) begin strobe_cnt_a++; last_strobe_a = wr_strobe_a; end
    if (frame_err_a) err_cnt_a++;
    if (wr_strobe_b != '0) begin strobe_cnt_b++; last_strobe_b = wr_strobe_b; end
    if (frame_err_b) err_cnt_b++;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Mode-0 host: copi set while sclk low, cipo sampled just before each rise; 8 clk per sclk.
  task automatic spi_frame(input bit sel_b, input int nbits, input int fw, input logic [31:0] frame,
                           input int rst_bit, output logic [31:0] rx, output logic oe_seen);
    logic [31:0] f;
    f = frame;
    rx = '0;
    oe_seen = 1'b0;
    if (sel_b) ncs_b = 1'b0; else ncs_a = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      copi = (i < fw) ? f[fw-1-i] : 1'b0;
      repeat (4) @(negedge clk);
      rx = {rx[30:0], (sel_b ? spi_b.cipo : spi_a.cipo)};
      oe_seen = sel_b ? spi_b.cipo_oe : spi_a.cipo_oe;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    ncs_a = 1'b1;
    ncs_b = 1'b1;
    copi = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  logic [31:0] rx;
  logic        oe;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_regs_a", 256'(regs_flat_a), 256'h0);
    check("reset_strobe_a", 256'(wr_strobe_a), 256'h0);
    check("reset_err_a", 256'(frame_err_a), 256'h0);
    check("reset_cipo_a", 256'(spi_a.cipo), 256'h0);
    check("reset_oe_a", 256'(spi_a.cipo_oe), 256'h0);
    check("reset_regs_b", regs_flat_b, 256'h0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Test 1: write 0xA5 to register 3
    spi_frame(1'b0, 16, 16, 32'h83A5, -1, rx, oe);
    check("t1_regs", 256'(regs_flat_a), 256'h0000_0000_A500_0000);
    check("t1_strobe_cnt", 256'(strobe_cnt_a), 256'd1);
    check("t1_strobe_val", 256'(last_strobe_a), 256'h08);
    check("t1_no_err", 256'(err_cnt_a), 256'd0);
    check("t1_oe_write", 256'(oe), 256'h0);

    // Test 2: load regs[5]=0x3C, read it back
    spi_frame(1'b0, 16, 16, 32'h853C, -1, rx, oe);
    check("t2_regs", 256'(regs_flat_a), 256'h0000_3C00_A500_0000);
    spi_frame(1'b0, 16, 16, 32'h0500, -1, rx, oe);
    check("t2_read_data", 256'(rx[7:0]), 256'h3C);
    check("t2_read_oe", 256'(oe), 256'h1);
    check("t2_oe_after", 256'(spi_a.cipo_oe), 256'h0);
    check("t2_read_no_strobe", 256'(strobe_cnt_a), 256'd2);

    // Test 3: abort after 10 bits, then a full frame must still work
    spi_frame(1'b0, 10, 16, 32'h81FF, -1, rx, oe);
    check("t3_regs_kept", 256'(regs_flat_a), 256'h0000_3C00_A500_0000);
    check("t3_err_once", 256'(err_cnt_a), 256'd1);
    check("t3_no_strobe", 256'(strobe_cnt_a), 256'd2);
    spi_frame(1'b0, 16, 16, 32'h8111, -1, rx, oe);
    check("t3_recover_regs", 256'(regs_flat_a), 256'h0000_3C00_A500_1100);
    check("t3_recover_strobe", 256'(last_strobe_a), 256'h02);

    // Test 4: overrun, out-of-range write and read
    spi_frame(1'b0, 17, 16, 32'h8277, -1, rx, oe);
    check("t4_overrun_regs", 256'(regs_flat_a), 256'h0000_3C00_A500_1100);
    check("t4_overrun_err", 256'(err_cnt_a), 256'd2);
    check("t4_overrun_strobe", 256'(strobe_cnt_a), 256'd3);
    spi_frame(1'b0, 16, 16, 32'hFF55, -1, rx, oe);
    check("t4_oor_write_regs", 256'(regs_flat_a), 256'h0000_3C00_A500_1100);
    check("t4_oor_write_strobe", 256'(strobe_cnt_a), 256'd3);
    check("t4_oor_write_err", 256'(err_cnt_a), 256'd2);
    spi_frame(1'b0, 16, 16, 32'h7F00, -1, rx, oe);
    check("t4_oor_read_data", 256'(rx[7:0]), 256'h00);
    check("t4_oor_read_oe", 256'(oe), 256'h1);

    // Test 5: reset in the middle of a write frame
    spi_frame(1'b0, 16, 16, 32'h84AA, 6, rx, oe);
    check("t5_regs_cleared", 256'(regs_flat_a), 256'h0);
    check("t5_no_strobe", 256'(strobe_cnt_a), 256'd3);
    check("t5_no_err", 256'(err_cnt_a), 256'd2);
    spi_frame(1'b0, 16, 16, 32'h84AA, -1, rx, oe);
    check("t5_next_regs", 256'(regs_flat_a), 256'h0000_00AA_0000_0000);
    check("t5_next_strobe", 256'(last_strobe_a), 256'h10);

    // Test 6: 16x16 variant, register 15
    spi_frame(1'b1, 21, 21, 32'h1FBEEF, -1, rx, oe);
    check("t6_regs_b", regs_flat_b, {16'hBEEF, 240'h0});
    check("t6_strobe_b", 256'(last_strobe_b), 256'h8000);
    check("t6_strobe_cnt_b", 256'(strobe_cnt_b), 256'd1);
    spi_frame(1'b1, 21, 21, 32'h0F0000, -1, rx, oe);
    check("t6_read_b", 256'(rx[15:0]), 256'hBEEF);
    check("t6_read_oe_b", 256'(oe), 256'h1);
    check("t6_err_b", 256'(err_cnt_b), 256'd0);
    check("t6_a_untouched", 256'(regs_flat_a), 256'h0000_00AA_0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
